// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: bang-bang phase detector and loop filter driving rotator inc/dec pulses with lock tracking
module cdr_loop_filter #(
  parameter int ACC_W      = 6,
  parameter int THRESH_ACQ = 4,
  parameter int THRESH_TRK = 16,
  parameter int HOLDOFF    = 4,
  parameter int LOCK_WIN   = 64,
  parameter int UNLOCK_N   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s_valid,
  input  logic s_early,
  input  logic s_edge,
  input  logic s_late,
  output logic inc,
  output logic dec,
  output logic locked
);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam int QW = $clog2(LOCK_WIN + 1);
  localparam int RW = $clog2(UNLOCK_N + 1);
  localparam logic signed [ACC_W-1:0] TA = ACC_W'(THRESH_ACQ);
  localparam logic signed [ACC_W-1:0] TT = ACC_W'(THRESH_TRK);
  typedef enum logic {ACQ, TRK} state_t;
  state_t state, state_nx;
  logic vote_up, vote_dn;
  logic signed [ACC_W-1:0] acc, acc_nx, acc_sum, thr, step;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [QW-1:0] quiet_cnt, quiet_nx;
  logic [RW-1:0] run_cnt, run_nx;
  logic run_dir, run_dir_nx, hold, p_up, p_dn, pulse;
  // Stage 1: Alexander early/late vote from the data/edge/data triple
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vote_up <= 1'b0;
      vote_dn <= 1'b0;
    end else begin
      vote_up <= en && s_valid && (s_early != s_late) && (s_edge == s_early);
      vote_dn <= en && s_valid && (s_early != s_late) && (s_edge == s_late);
    end
  // Stage 2 datapath and ACQUIRE/TRACK next-state: integrate, threshold, hold-off, lock bookkeeping
  always_comb begin
    hold = hold_cnt != '0;
    thr = state == TRK ? TT : TA;
    step = {{(ACC_W-1){vote_dn}}, vote_up | vote_dn};
    acc_sum = acc + step;
    p_up = !hold && acc_sum >= thr;
    p_dn = !hold && acc_sum <= -thr;
    pulse = p_up || p_dn;
    hold_nx = pulse ? HW'(HOLDOFF) : hold ? hold_cnt - 1'b1 : hold_cnt;
    acc_nx = (hold || pulse) ? '0 : acc_sum;
    state_nx = state;
    quiet_nx = quiet_cnt;
    run_nx = run_cnt;
    run_dir_nx = run_dir;
    if (state == ACQ) begin
      quiet_nx = pulse ? '0 : quiet_cnt + 1'b1;
      if (!pulse && quiet_cnt == QW'(LOCK_WIN - 1)) begin
        state_nx = TRK;
        quiet_nx = '0;
        acc_nx = '0;
      end
    end else if (pulse) begin
      run_nx = (run_cnt != '0 && run_dir == p_up) ? run_cnt + 1'b1 : RW'(1);
      run_dir_nx = p_up;
      if (run_nx == RW'(UNLOCK_N)) begin
        state_nx = ACQ;
        run_nx = '0;
        quiet_nx = '0;
      end
    end
  end
  // State registers; a low enable freezes the loop in a cleared ACQUIRE state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ACQ;
      acc <= '0;
      hold_cnt <= '0;
      quiet_cnt <= '0;
      run_cnt <= '0;
      run_dir <= 1'b0;
      inc <= 1'b0;
      dec <= 1'b0;
    end else begin
      state <= en ? state_nx : ACQ;
      acc <= en ? acc_nx : '0;
      hold_cnt <= en ? hold_nx : '0;
      quiet_cnt <= en ? quiet_nx : '0;
      run_cnt <= en ? run_nx : '0;
      run_dir <= en && run_dir_nx;
      inc <= en && p_up;
      dec <= en && p_dn;
    end
  assign locked = state == TRK;
endmodule

// File: doc/cdr_loop_filter.md
# cdr_loop_filter

Bang-bang phase detector plus digital loop filter that drives the phase rotator's `inc`/`dec` control inputs in the CDR. It takes data/edge/data samples taken on the early, edge and late clocks and derives an early/late vote each cycle (Alexander-style). It integrates the votes in a signed accumulator and issues single-cycle, mutually exclusive `inc`/`dec` pulses. A hold-off window follows each pulse, and an ACQUIRE/TRACK state machine provides a lock indication.

## Interface
- `ACC_W`, 6: accumulator width, signed.
- `THRESH_ACQ`, 4: pulse threshold in ACQUIRE. Must be < 2^(ACC_W-1).
- `THRESH_TRK`, 16: pulse threshold in TRACK. Must be < 2^(ACC_W-1).
- `HOLDOFF`, 4: cycles after a pulse during which votes are discarded. A value of 0 disables hold-off.
- `LOCK_WIN`, 64: consecutive pulse-free enabled cycles in ACQUIRE needed to declare lock.
- `UNLOCK_N`, 4: consecutive same-direction pulses in TRACK that drop lock.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: loop enable; when low, the filter is frozen and cleared.
- `s_valid` in 1: sample triple valid this cycle.
- `s_early` in 1: data sample on early clock (previous bit, d0).
- `s_edge` in 1: sample on edge clock (e).
- `s_late` in 1: data sample on late clock (next bit, d1).
- `inc` out 1: advance rotator one step; 1-cycle pulse, registered.
- `dec` out 1: retard rotator one step; 1-cycle pulse, registered.
- `locked` out 1: high in TRACK.

## Operation
- Phase detector, registered stage 1, updated every edge:
  - No vote when `en`=0, `s_valid`=0, or `s_early`==`s_late`.
  - `s_edge`==`s_early` (transition after the edge sample) → vote_up, the clock is early.
  - `s_edge`==`s_late` → vote_dn.
  - vote_up and vote_dn are never both high.
- Accumulator, stage 2, signed ACC_W bits:
  - acc_next = acc + 1 on vote_up, acc − 1 on vote_dn, otherwise unchanged.
  - THR = THRESH_ACQ in ACQUIRE, THRESH_TRK in TRACK.
  - acc_next ≥ +THR → `inc`=1 for one cycle and acc ← 0.
  - acc_next ≤ −THR → `dec`=1 for one cycle and acc ← 0.
  - Otherwise acc ← acc_next.
  - No saturation is needed because acc clears at threshold.
- Hold-off:
  - Any pulse loads hold_cnt ← HOLDOFF.
  - While hold_cnt ≠ 0, votes are discarded, acc is held at 0 and hold_cnt decrements.
- State machine, 2 states:
  - ACQUIRE: quiet_cnt counts enabled cycles with no pulse and clears on any pulse. When quiet_cnt reaches LOCK_WIN−1 with no pulse that cycle → TRACK and acc ← 0.
  - TRACK: run_cnt counts consecutive pulses in the same direction. An opposite-direction pulse sets run_cnt ← 1. When the UNLOCK_N-th same-direction pulse issues → ACQUIRE, quiet_cnt ← 0, and that pulse is still emitted.
  - `locked` = (state==TRACK), registered.
- `en`=0:
  - acc, hold_cnt, quiet_cnt and run_cnt clear; state ← ACQUIRE.
  - No pulses; the stage-1 vote is forced to none.
- Reset values: `inc`=0, `dec`=0, `locked`=0, acc=0, all counters 0, state=ACQUIRE, vote regs 0.
- Reset mid-operation takes effect asynchronously: a pending or asserted pulse is dropped immediately.
- Invariant: `inc`&`dec` is never 1.
- Counter widths are $clog2-derived from their parameters.

## Timing
- A sample presented before edge k is registered as a vote at edge k.
- The vote is accumulated at edge k+1.
- A pulse caused by that vote is high from edge k+1 to edge k+2.
- Minimum pulse spacing is HOLDOFF + THR cycles; pulses are never back-to-back when HOLDOFF ≥ 1.
- `locked` changes at the same edge that changes state.
- `en` deassert at edge k: no pulse after edge k. The vote registered at edge k is discarded.

## Test plan
- Reset then idle with `en`=1, `s_valid`=0 for 100 cycles:
  - outputs stay 0 until quiet count completes;
  - `locked` rises after edge 63;
  - no pulses.
- Continuous early pattern (d0=0, e=0, d1=1), `s_valid`=1 from edge 0, defaults, in ACQUIRE:
  - `inc` high after edges 4, 12, 20, …, a period of 8;
  - `dec` never asserts.
- Continuous late pattern (d0=0, e=1, d1=1):
  - `dec` at the same cycle positions as the early case;
  - acc min reaches −3 between pulses.
- Alternating up/down votes for 200 cycles:
  - no pulses;
  - `locked`=1 after 64 cycles;
  - no lock loss.
- Locked, then continuous early pattern:
  - `inc` every 20 cycles (16 + hold-off);
  - `locked` drops the cycle after the 4th `inc`;
  - later pulses use THRESH_ACQ spacing of 8.
- Early pattern with `rst` pulsed low mid-accumulation (acc=3), then `en` toggled low for 1 cycle:
  - all outputs 0 immediately on reset;
  - the accumulation restarts from 0;
  - the first `inc` is exactly 5 edges after release/re-enable.
